// File: rtl/maxpool_flatten.sv
// 2x2 stride-2 max pooling with full-frame buffer, replayed as a flattened ce burst.
// Optional build macro MAXPOOL_RELU_EN clamps negative pooled values to zero before storage.
module maxpool_flatten #(
  parameter int unsigned I_BW   = 16,
  parameter int unsigned I_SIZE = 8,
  parameter int unsigned CI     = 12
) (
  input  logic                   clk,
  input  logic                   global_rst,
  input  logic                   rst_processEnd,
  input  logic signed [I_BW-1:0] i_data,
  input  logic                   i_valid,
  output logic                   i_ready,
  output logic signed [I_BW-1:0] o_data,
  output logic                   o_ce,
  output logic                   o_done
);

  localparam int unsigned O_SIZE = I_SIZE / 2;
  localparam int unsigned N_OUT  = O_SIZE * O_SIZE * CI;
  localparam int unsigned CW     = (I_SIZE > 1) ? $clog2(I_SIZE) : 1;
  localparam int unsigned CHW    = (CI > 1) ? $clog2(CI) : 1;
  localparam int unsigned OW     = (O_SIZE > 1) ? $clog2(O_SIZE) : 1;
  localparam int unsigned AW     = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {
    StCollect = 2'd0,
    StDrain   = 2'd1,
    StDone    = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]  col_q, col_d;
  logic [CW-1:0]  row_q, row_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [AW-1:0]  rd_idx_q, rd_idx_d;

  logic signed [I_BW-1:0] o_data_d;
  logic                   o_ce_d;
  logic                   o_done_d;

  logic signed [I_BW-1:0] prev_q;
  logic signed [I_BW-1:0] linebuf [O_SIZE];
  logic signed [I_BW-1:0] fbuf    [N_OUT];

  logic                   clear;
  logic                   accept;
  logic                   col_last;
  logic                   row_last;
  logic                   ch_last;
  logic [OW-1:0]          col_half;
  logic [AW-1:0]          wr_addr;
  logic signed [I_BW-1:0] line_val;
  logic signed [I_BW-1:0] h_max;
  logic signed [I_BW-1:0] p_max;
  logic signed [I_BW-1:0] p_wr;

  // Both clears have identical effect, so priority between them collapses to an OR.
  assign clear    = global_rst | rst_processEnd;
  assign i_ready  = (state_q == StCollect);
  assign accept   = i_valid & i_ready & ~clear;

  assign col_last = (col_q == CW'(I_SIZE - 1));
  assign row_last = (row_q == CW'(I_SIZE - 1));
  assign ch_last  = (ch_q == CHW'(CI - 1));

  assign col_half = OW'(col_q >> 1);
  assign wr_addr  = AW'(ch_q) * AW'(O_SIZE * O_SIZE)
                  + AW'(row_q >> 1) * AW'(O_SIZE)
                  + AW'(col_half);

  // Pooling datapath: horizontal pair max, then vertical max against the line buffer.
  assign line_val = linebuf[col_half];
  assign h_max    = (i_data > prev_q) ? i_data : prev_q;
  assign p_max    = (line_val > h_max) ? line_val : h_max;

`ifdef MAXPOOL_RELU_EN
  assign p_wr = p_max[I_BW-1] ? '0 : p_max;
`else
  assign p_wr = p_max;
`endif

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    ch_d     = ch_q;
    rd_idx_d = rd_idx_q;
    o_data_d = '0;
    o_ce_d   = 1'b0;
    o_done_d = 1'b0;

    unique case (state_q)
      StCollect: begin
        if (accept) begin
          if (col_last) begin
            col_d = '0;
            if (row_last) begin
              row_d = '0;
              if (ch_last) begin
                ch_d    = '0;
                state_d = StDrain;
              end else begin
                ch_d = ch_q + 1'b1;
              end
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      StDrain: begin
        o_ce_d   = 1'b1;
        o_data_d = fbuf[rd_idx_q];
        if (rd_idx_q == AW'(N_OUT - 1)) begin
          rd_idx_d = '0;
          state_d  = StDone;
        end else begin
          rd_idx_d = rd_idx_q + 1'b1;
        end
      end

      StDone: begin
        o_done_d = 1'b1;
      end

      default: begin
        state_d = StCollect;
      end
    endcase

    if (clear) begin
      state_d  = StCollect;
      col_d    = '0;
      row_d    = '0;
      ch_d     = '0;
      rd_idx_d = '0;
      o_data_d = '0;
      o_ce_d   = 1'b0;
      o_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q  <= state_d;
    col_q    <= col_d;
    row_q    <= row_d;
    ch_q     <= ch_d;
    rd_idx_q <= rd_idx_d;
    o_data   <= o_data_d;
    o_ce     <= o_ce_d;
    o_done   <= o_done_d;
  end

  // Buffers are never reset: every entry is written during collection before the drain reads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (!col_q[0]) begin
        prev_q <= i_data;
      end else if (!row_q[0]) begin
        linebuf[col_half] <= h_max;
      end else begin
        fbuf[wr_addr] <= p_wr;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_flatten.sv
// Self-checking bench for maxpool_flatten: table of frame scenarios checked against a pooling model.
`timescale 1ns/1ps
module tb_maxpool_flatten;

  localparam int I_BW   = 16;
  localparam int I_SIZE = 8;
  localparam int CI     = 12;
  localparam int O_SIZE = I_SIZE / 2;
  localparam int N_IN   = I_SIZE * I_SIZE * CI;
  localparam int N_OUT  = O_SIZE * O_SIZE * CI;
  localparam int NOCHK  = -100000;
`ifdef MAXPOOL_RELU_EN
  localparam int NEG_OUT = 0;
`else
  localparam int NEG_OUT = -5;
`endif

  logic                   clk = 1'b0;
  logic                   global_rst;
  logic                   rst_processEnd;
  logic signed [I_BW-1:0] i_data;
  logic                   i_valid;
  logic                   i_ready;
  logic signed [I_BW-1:0] o_data;
  logic                   o_ce;
  logic                   o_done;

  always #5 clk = ~clk;

  maxpool_flatten #(
    .I_BW   (I_BW),
    .I_SIZE (I_SIZE),
    .CI     (CI)
  ) dut (
    .clk            (clk),
    .global_rst     (global_rst),
    .rst_processEnd (rst_processEnd),
    .i_data         (i_data),
    .i_valid        (i_valid),
    .i_ready        (i_ready),
    .o_data         (o_data),
    .o_ce           (o_ce),
    .o_done         (o_done)
  );

  typedef struct {
    int pat;        // 0: ch+1, 1: ch0 ramp, 2: all -5, 3: random
    int gap;        // percent of cycles with i_valid low
    int pre_clear;  // partial frame then rst_processEnd before the real frame
    int abort;      // 0: none, 1: global_rst at 50th ce, 2: both resets
    int exp_first;
    int exp_last;
  } vec_t;

  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;
  int   fr[N_IN];
  int   exp_o[N_OUT];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int pat);
    for (int c = 0; c < CI; c++)
      for (int r = 0; r < I_SIZE; r++)
        for (int x = 0; x < I_SIZE; x++) begin
          int idx;
          idx = c * I_SIZE * I_SIZE + r * I_SIZE + x;
          case (pat)
            0:       fr[idx] = c + 1;
            1:       fr[idx] = (c == 0) ? r * I_SIZE + x : 0;
            2:       fr[idx] = -5;
            default: fr[idx] = int'($urandom_range(0, 65535)) - 32768;
          endcase
        end
  endtask

  // Reference: max over each 2x2 window, flattened channel-major then row-major.
  task automatic build_model();
    for (int c = 0; c < CI; c++)
      for (int pr = 0; pr < O_SIZE; pr++)
        for (int pc = 0; pc < O_SIZE; pc++) begin
          int m;
          m = fr[c * I_SIZE * I_SIZE + 2 * pr * I_SIZE + 2 * pc];
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
              if (fr[c * I_SIZE * I_SIZE + (2 * pr + dr) * I_SIZE + 2 * pc + dc] > m)
                m = fr[c * I_SIZE * I_SIZE + (2 * pr + dr) * I_SIZE + 2 * pc + dc];
`ifdef MAXPOOL_RELU_EN
          if (m < 0) m = 0;
`endif
          exp_o[c * O_SIZE * O_SIZE + pr * O_SIZE + pc] = m;
        end
  endtask

  task automatic feed(input int gap, input int stop_after, output int accepted);
    int idx;
    int budget;
    int ce_seen;
    bit acc;
    idx     = 0;
    budget  = 20 * N_IN;
    ce_seen = 0;
    while (idx < stop_after && budget > 0) begin
      i_data  = I_BW'(fr[idx]);
      i_valid = (gap == 0) ? 1'b1 : (int'($urandom_range(0, 99)) >= gap);
      acc     = i_valid && i_ready;
      step();
      if (acc) idx++;
      if (o_ce) ce_seen++;
      budget--;
    end
    if (budget == 0) chk("feed_timeout", idx, stop_after);
    chk("no_ce_while_collecting", ce_seen, 0);
    // Keep offering junk to prove it is ignored once the block stops accepting.
    i_valid  = 1'b1;
    i_data   = 16'sh7fff;
    accepted = idx;
  endtask

  task automatic drain(input int abort, input int first_exp, input int last_exp);
    chk("ce_low_cycle_after_last_accept", int'(o_ce), 0);
    step();
    for (int k = 0; k < N_OUT; k++) begin
      chk("ce_burst_contiguous", int'(o_ce), 1);
      chk("o_data_vs_model", int'(o_data), exp_o[k]);
      if (k == 0 && first_exp != NOCHK) chk("first_output", int'(o_data), first_exp);
      if (k == N_OUT - 1 && last_exp != NOCHK) chk("last_output", int'(o_data), last_exp);
      if (abort != 0 && k == 49) begin
        global_rst     = 1'b1;
        rst_processEnd = (abort == 2);
        step();
        global_rst     = 1'b0;
        rst_processEnd = 1'b0;
        i_valid        = 1'b0;
        chk("abort_ce", int'(o_ce), 0);
        chk("abort_data", int'(o_data), 0);
        chk("abort_done", int'(o_done), 0);
        chk("abort_ready", int'(i_ready), 1);
        return;
      end
      step();
    end
    chk("ce_low_after_burst", int'(o_ce), 0);
    chk("data_zero_after_burst", int'(o_data), 0);
    chk("done_after_burst", int'(o_done), 1);
    chk("ready_low_in_done", int'(i_ready), 0);
    repeat (5) step();
    chk("done_held", int'(o_done), 1);
    chk("ce_stays_low", int'(o_ce), 0);
    rst_processEnd = 1'b1;
    step();
    rst_processEnd = 1'b0;
    i_valid        = 1'b0;
    chk("clear_from_done_done", int'(o_done), 0);
    chk("clear_from_done_ready", int'(i_ready), 1);
  endtask

  initial begin
    int n;
    vecs[0] = '{pat: 0, gap: 0,  pre_clear: 0, abort: 0, exp_first: 1,       exp_last: 12};
    vecs[1] = '{pat: 1, gap: 0,  pre_clear: 0, abort: 0, exp_first: 9,       exp_last: 0};
    vecs[2] = '{pat: 2, gap: 0,  pre_clear: 0, abort: 0, exp_first: NEG_OUT, exp_last: NEG_OUT};
    vecs[3] = '{pat: 1, gap: 30, pre_clear: 0, abort: 0, exp_first: 9,       exp_last: 0};
    vecs[4] = '{pat: 0, gap: 0,  pre_clear: 1, abort: 0, exp_first: 1,       exp_last: 12};
    vecs[5] = '{pat: 0, gap: 0,  pre_clear: 0, abort: 1, exp_first: 1,       exp_last: NOCHK};
    vecs[6] = '{pat: 0, gap: 0,  pre_clear: 0, abort: 2, exp_first: 1,       exp_last: NOCHK};
    vecs[7] = '{pat: 3, gap: 20, pre_clear: 0, abort: 0, exp_first: NOCHK,   exp_last: NOCHK};
    vecs[8] = '{pat: 0, gap: 0,  pre_clear: 0, abort: 0, exp_first: 1,       exp_last: 12};

    global_rst     = 1'b1;
    rst_processEnd = 1'b0;
    i_valid        = 1'b0;
    i_data         = '0;
    repeat (3) step();
    global_rst = 1'b0;
    chk("reset_ce", int'(o_ce), 0);
    chk("reset_data", int'(o_data), 0);
    chk("reset_done", int'(o_done), 0);
    chk("reset_ready", int'(i_ready), 1);

    for (int v = 0; v < 9; v++) begin
      i_valid = 1'b0;
      step();
      if (vecs[v].pre_clear != 0) begin
        fill(1);
        feed(0, 100, n);
        // Clear coincides with a valid sample: the sample must be dropped.
        i_data         = I_BW'(fr[100]);
        i_valid        = 1'b1;
        rst_processEnd = 1'b1;
        step();
        rst_processEnd = 1'b0;
        i_valid        = 1'b0;
        chk("partial_clear_ready", int'(i_ready), 1);
        chk("partial_clear_ce", int'(o_ce), 0);
      end
      fill(vecs[v].pat);
      build_model();
      feed(vecs[v].gap, N_IN, n);
      chk("accept_count", n, N_IN);
      chk("ready_low_after_frame", int'(i_ready), 0);
      drain(vecs[v].abort, vecs[v].exp_first, vecs[v].exp_last);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxpool_flatten.md
Name: maxpool_flatten

Overview:
Pooling and flatten stage that sits directly upstream of the fully connected classifier.
- Accepts the final convolution layer's feature maps as a serial stream: CI channels, each I_SIZE x I_SIZE, row-major, channel-major.
- Performs 2x2 stride-2 max pooling and buffers the full pooled frame.
- Replays the frame as a contiguous one-value-per-cycle burst with a ce strobe, in the exact flattened order the classifier's weight index expects.

Parameters:
I_BW, 16, signed data width of input and output samples
I_SIZE, 8, input feature-map side; must be even; O_SIZE = I_SIZE/2 is a localparam
CI, 12, number of channels
(localparam) N_OUT = O_SIZE*O_SIZE*CI = 192 at defaults; counter widths are clog2-derived

Ports:
clk  input  1  clock
global_rst  input  1  synchronous active-high reset
rst_processEnd  input  1  synchronous frame clear; same effect as reset; global_rst has priority
i_data  input  I_BW  signed input sample
i_valid  input  1  sample valid
i_ready  output  1  block accepts a sample this cycle
o_data  output  I_BW  signed pooled value to classifier i_data
o_ce  output  1  o_data valid; drives classifier ce
o_done  output  1  level; burst complete, frame held

Behaviour:
- One clock, clk. Reset is synchronous and active-high on global_rst. rst_processEnd applies identical clears, one priority level below global_rst.
- Reset/clear values:
  - State = S_COLLECT.
  - All counters = 0.
  - o_data = 0, o_ce = 0, o_done = 0.
  - Line buffer and frame buffer contents need not be cleared; every entry is written before it is read.
- i_ready is combinational and equals 1 only in S_COLLECT. A sample is accepted when i_valid && i_ready. i_valid while i_ready = 0 is ignored and no data is lost internally.
- Position counters col, row and ch advance only on an accepted sample:
  - col wraps at I_SIZE-1 and increments row.
  - row wraps at I_SIZE-1 and increments ch.
- Pooling datapath, per accepted sample:
  - Even col: latch the sample into prev.
  - Odd col: h = max(prev, sample), signed compare.
  - Even row: store h in linebuf[col>>1] (O_SIZE entries).
  - Odd row: p = max(linebuf[col>>1], h). Write p to fbuf[ch*O_SIZE*O_SIZE + (row>>1)*O_SIZE + (col>>1)].
  - No width growth; max is a selection.
- FSM:
  - S_COLLECT -> S_DRAIN: the cycle the last sample is accepted (ch = CI-1, row = col = I_SIZE-1). That same edge writes the last fbuf entry.
  - S_DRAIN: rd_idx runs from 0 to N_OUT-1, one per cycle. o_data and o_ce are registered, so the first o_ce = 1 appears 2 cycles after the last input acceptance. o_ce stays high for exactly N_OUT consecutive cycles, carrying fbuf[0..N_OUT-1] in order. There are no gaps and no backpressure.
  - S_DRAIN -> S_DONE: after rd_idx = N_OUT-1 has been issued.
  - S_DONE: o_ce = 0 from the cycle after the last value. o_data returns to 0. o_done = 1 and is held. i_ready = 0. The state is left only on rst_processEnd or global_rst.
- Reset or rst_processEnd mid-collection or mid-drain: takes effect at the next edge. o_ce is 0 from the following cycle and any partial frame is discarded.
- rst_processEnd and i_valid in the same cycle: the clear wins and the sample is not accepted.

Optional Feature:
MAXPOOL_RELU_EN
- Defined: each written pooled value p is clamped, so p < 0 writes 0 (ReLU fused after the max).
- Undefined: the raw signed max is written unchanged.
- Compare logic, latency and FSM are identical either way.

Test Plan:
1. Every sample of channel c equals c+1, i_valid held high -> i_ready drops after 768 accepts; o_ce is high for exactly 192 consecutive cycles starting 2 cycles later; o_data = 1 x16, 2 x16, ..., 12 x16; then o_done = 1 and stays.
2. Channel 0 sample = row*8+col, other channels 0 -> first 16 outputs are 9,11,13,15,25,27,29,31,41,43,45,47,57,59,61,63, then 176 zeros.
3. All samples = -5 -> with MAXPOOL_RELU_EN all 192 outputs = 0; without it all 192 outputs = 0xFFFB.
4. Scenario 2 stimulus with i_valid randomly low ~30% of cycles -> output identical to scenario 2; o_ce burst is still contiguous.
5. rst_processEnd pulsed after 100 accepted samples, then a full scenario-1 frame -> no o_ce before the new frame completes; output matches scenario 1; rst_processEnd in S_DONE -> o_done = 0 and i_ready = 1 next cycle.
6. global_rst asserted at the 50th o_ce cycle -> o_ce = 0, o_data = 0, o_done = 0 the cycle after; global_rst together with rst_processEnd behaves as global_rst.
